mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the word-addressed data memory port: accepts byte-addressed load/store requests from the multicycle core and drives the memory's address, write data and write enable. Captures the combinational read data.
- Performs byte/halfword extraction with sign or zero extension on loads, and read-modify-write for sub-word stores.
- Sits between the core's execute/mem stage and the data memory instance.

Parameters:
- ADDR_W, 8, word-address width of the memory (256 words; byte space 0..4*2^ADDR_W-1).
- DATA_W, 32, memory word width; fixed at 32, byte lanes assume 4 bytes/word.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_op  in  4  bit3=store; [2:0]: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned (unsigned forms are load-only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low bits used for sub-word.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores/errors.
- resp_err  out  1  qualifies resp_valid: misaligned, out-of-range or illegal op.
- mem_a  out  32  word address to memory (zero-extended).
- mem_wd  out  32  write data to memory.
- mem_we  out  1  memory write enable.
- mem_rd  in  32  memory read data, combinational from mem_a.

Behaviour:
- Reset: state IDLE. req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_a=0, mem_wd=0, mem_we=0, all latched request registers 0.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch op/addr/wdata and run checks. Any check fails -> RESP with err. Otherwise -> ACCESS.
  - ACCESS: mem_a = addr[ADDR_W+1:2].
    - Load: register mem_rd -> RESP.
    - SW: mem_wd=wdata, mem_we=1 -> RESP.
    - SB/SH: register mem_rd -> WRITE.
  - WRITE: mem_a held; mem_wd = registered word with the selected lane(s) replaced by wdata[7:0] or wdata[15:0]; mem_we=1 -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE.
- mem_we is asserted only in ACCESS (SW) or WRITE; never in IDLE or RESP.
- Latency, accept edge to resp_valid high:
  - error: 1 cycle.
  - load / SW: 2 cycles.
  - SB / SH: 3 cycles.
  - Throughput: a new request is accepted at the earliest in the cycle after RESP.
- Checks, evaluated in IDLE:
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - out-of-range: addr[31:ADDR_W+2] != 0.
  - illegal op: store with [2]=1, or [2:0] in {011, 110, 111}.
  - Any failure: no memory access, mem_we stays 0, resp_err=1, resp_rdata=0.
- Lanes are little-endian: byte k at bits [8k+7:8k]; halfword at addr[1]=0 -> [15:0], addr[1]=1 -> [31:16].
- Load extension: signed ops replicate the MSB of the selected lane; unsigned ops zero-fill; word passes through.
- resp_rdata/resp_err are held from RESP until the next RESP; they are meaningful only while resp_valid=1.
- req_valid while not ready is ignored (not queued); the requester must hold it until ready.
- rst asserted in any state: next state IDLE, all outputs at reset values.
  - A write whose mem_we=1 cycle coincides with rst still lands at that edge (memory has no reset).
  - No response is issued for the aborted request.
- Sub-word store atomicity relies on this unit being the sole memory initiator.

Decomposition:
- Shared package mem_pkg: op encodings (OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW), state encoding (IDLE, ACCESS, WRITE, RESP), and the BYTES_PER_WORD constant.
- One combinational sub-module, lane_align: given word, addr[1:0] and op, produces the extended load value and the merged store word. The FSM and registers stay in mem_access_unit.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_we=1 with mem_a=4 for one cycle; resp_rdata=0xDEADBEEF; LW resp_valid 2 cycles after accept.
- With word 4 = 0xDEADBEEF: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 data 0x00000055 onto 0xDEADBEEF -> WRITE drives mem_wd=0xDEAD55EF; resp 3 cycles after accept; following LW 0x10 returns 0xDEAD55EF.
- LW 0x12, SH 0x11, LW 0x400 and op 1100 -> each resp_err=1 one cycle after accept, resp_rdata=0, mem_we never asserted; memory contents unchanged.
- Back-to-back requests with req_valid held high -> req_ready low in ACCESS/WRITE/RESP; the second request is accepted in the cycle after RESP; no request is dropped or duplicated.
- rst asserted during the ACCESS state of an SH -> no WRITE cycle, no resp_valid; the unit is in IDLE with reset outputs on the next cycle; memory word unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit.
// Holds the request op encodings, the FSM state type, lane geometry constants
// and the request legality/alignment helpers used by the accept logic.
package mem_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned OFF_W          = $clog2(BYTES_PER_WORD);
    localparam int unsigned OP_W           = 4;

    // op[3] = store, op[2] = unsigned (loads only), op[1:0] = size
    localparam logic [OP_W-1:0] OP_LB  = 4'b0000;
    localparam logic [OP_W-1:0] OP_LH  = 4'b0001;
    localparam logic [OP_W-1:0] OP_LW  = 4'b0010;
    localparam logic [OP_W-1:0] OP_LBU = 4'b0100;
    localparam logic [OP_W-1:0] OP_LHU = 4'b0101;
    localparam logic [OP_W-1:0] OP_SB  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SH  = 4'b1001;
    localparam logic [OP_W-1:0] OP_SW  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        RESP
    } state_t;

    // True only for the eight defined encodings.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        logic ok;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: ok = 1'b1;
            default:                                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords need an even byte address, words a multiple of four.
    function automatic logic misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
        return ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != '0));
    endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering between a 32-bit little-endian memory word and the core.
// Ports:
//   word          memory word currently addressed
//   offset        byte offset within the word (addr[1:0])
//   op            request op (size / signedness / store)
//   wdata         store data, sub-word values in the low bits
//   load_data_c   selected lane, sign- or zero-extended for loads
//   store_word_c  word with the addressed lane(s) replaced by store data
module lane_align
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [OFF_W-1:0]  offset,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data_c,
    output logic [DATA_W-1:0] store_word_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane extraction and load extension.
    always_comb begin
        byte_sel    = word[{offset, 3'b000} +: 8];
        half_sel    = offset[1] ? word[31:16] : word[15:0];
        load_data_c = word;
        case (op)
            OP_LB:   load_data_c = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data_c = {24'h0, byte_sel};
            OP_LH:   load_data_c = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data_c = {16'h0, half_sel};
            default: load_data_c = word;
        endcase
    end

    // Read-modify-write merge for sub-word stores.
    always_comb begin
        store_word_c = wdata;
        case (op)
            OP_SB: begin
                store_word_c = word;
                store_word_c[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            OP_SH:   store_word_c = offset[1] ? {wdata[15:0], word[15:0]}
                                              : {word[31:16], wdata[15:0]};
            default: store_word_c = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator for the word-addressed data memory. Accepts byte-addressed
// load/store requests, performs alignment/range/op checks, sub-word load
// extension and read-modify-write for byte/halfword stores.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    request handshake
//   req_op/addr/wdata      request payload
//   resp_valid             one-cycle completion pulse
//   resp_rdata/resp_err    completion data and error flag
//   mem_a/mem_wd/mem_we    memory address (word), write data, write enable
//   mem_rd                 combinational memory read data
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [31:0]       mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);

    state_t            state;
    logic [OP_W-1:0]   op_q;
    logic [OFF_W-1:0]  off_q;
    logic [DATA_W-1:0] wdata_q;

    logic              req_bad_c;
    logic [DATA_W-1:0] load_data_c;
    logic [DATA_W-1:0] store_word_c;

    // Request rejected before any memory access is made.
    always_comb begin
        req_bad_c = !op_legal(req_op)
                 || misaligned(req_op[1:0], req_addr[OFF_W-1:0])
                 || (req_addr[31:ADDR_W+2] != '0);
    end

    lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .word         (mem_rd),
        .offset       (off_q),
        .op           (op_q),
        .wdata        (wdata_q),
        .load_data_c  (load_data_c),
        .store_word_c (store_word_c)
    );

    // Control FSM; every output is registered and set on entry to its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
            mem_we     <= 1'b0;
            op_q       <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        off_q     <= req_addr[OFF_W-1:0];
                        wdata_q   <= req_wdata;
                        if (req_bad_c) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state <= ACCESS;
                            mem_a <= 32'(req_addr[ADDR_W+1:2]);
                            // Full-word stores write during ACCESS itself.
                            if (req_op == OP_SW) begin
                                mem_wd <= req_wdata;
                                mem_we <= 1'b1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (!op_q[3]) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data_c;
                    end else if (op_q == OP_SW) begin
                        state      <= RESP;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end else begin
                        // Sub-word store: merge into the word just read.
                        state  <= WRITE;
                        mem_wd <= store_word_c;
                        mem_we <= 1'b1;
                    end
                end
                WRITE: begin
                    state      <= RESP;
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 256-word memory.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [256];

    int errors = 0;
    int checks = 0;

    // Observations of the most recent transaction.
    int          r_lat;
    int          r_we_cnt;
    logic [31:0] r_rdata;
    logic [31:0] r_wd;
    logic [31:0] r_a;
    logic        r_err;
    logic        r_valid_after;

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:0]];
    always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_wd;

    mem_access_unit #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    // Issue one request and record latency, write activity and response.
    task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
        int waited = 0;
        r_lat = -1; r_we_cnt = 0; r_rdata = '0; r_wd = '0; r_a = '0; r_err = 1'b0; r_valid_after = 1'b1;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (mem_we) begin
                r_we_cnt++;
                r_wd = mem_wd;
                r_a  = mem_a;
            end
            if (resp_valid) begin
                r_lat   = k;
                r_rdata = resp_rdata;
                r_err   = resp_err;
                @(negedge clk);
                r_valid_after = resp_valid;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if ({mem_a, mem_wd, resp_rdata, resp_err} !== 97'h0) begin
            errors++; $display("FAIL reset_regs a=%h wd=%h rdata=%h err=%b exp all 0", mem_a, mem_wd, resp_rdata, resp_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_word();
        do_req(OP_SW, 32'h10, 32'hDEADBEEF);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL sw_latency got=%0d exp=2", r_lat); end
        checks++; if (r_we_cnt !== 1) begin errors++; $display("FAIL sw_we_cycles got=%0d exp=1", r_we_cnt); end
        checks++; if (r_a !== 32'd4) begin errors++; $display("FAIL sw_mem_a got=%h exp=4", r_a); end
        checks++; if (r_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem_wd got=%h exp=deadbeef", r_wd); end
        checks++; if (r_valid_after !== 1'b0) begin errors++; $display("FAIL sw_pulse_width got=%b exp=0", r_valid_after); end
        do_req(OP_LW, 32'h10, 32'h0);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL lw_latency got=%0d exp=2", r_lat); end
        checks++; if (r_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got=%h exp=deadbeef", r_rdata); end
        checks++; if (r_err !== 1'b0 || r_we_cnt !== 0) begin errors++; $display("FAIL lw_err_we got err=%b we=%0d exp 0/0", r_err, r_we_cnt); end
    endtask

    task automatic test_subword_load();
        logic [3:0]  ops  [4] = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
        logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
        logic [31:0] exps [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
        for (int i = 0; i < 4; i++) begin
            do_req(ops[i], adrs[i], 32'h0);
            checks++; if (r_rdata !== exps[i] || r_lat !== 2 || r_err !== 1'b0) begin
                errors++; $display("FAIL subload_%0d got rdata=%h lat=%0d err=%b exp rdata=%h lat=2 err=0", i, r_rdata, r_lat, r_err, exps[i]);
            end
        end
    endtask

    task automatic test_subword_store();
        do_req(OP_SB, 32'h11, 32'h00000055);
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL sb_latency got=%0d exp=3", r_lat); end
        checks++; if (r_we_cnt !== 1 || r_a !== 32'd4) begin errors++; $display("FAIL sb_write got we=%0d a=%h exp 1/4", r_we_cnt, r_a); end
        checks++; if (r_wd !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_mem_wd got=%h exp=dead55ef", r_wd); end
        do_req(OP_LW, 32'h10, 32'h0);
        checks++; if (r_rdata !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_readback got=%h exp=dead55ef", r_rdata); end
        do_req(OP_SH, 32'h12, 32'hABCD1234);
        checks++; if (r_lat !== 3 || r_wd !== 32'h123455EF) begin errors++; $display("FAIL sh_write got lat=%0d wd=%h exp 3/123455ef", r_lat, r_wd); end
        do_req(OP_LW, 32'h10, 32'h0);
        checks++; if (r_rdata !== 32'h123455EF) begin errors++; $display("FAIL sh_readback got=%h exp=123455ef", r_rdata); end
    endtask

    task automatic test_errors();
        logic [3:0]  ops  [4] = '{OP_LW, OP_SH, OP_LW, 4'b1100};
        logic [31:0] adrs [4] = '{32'h12, 32'h11, 32'h400, 32'h10};
        for (int i = 0; i < 4; i++) begin
            do_req(ops[i], adrs[i], 32'hFFFFFFFF);
            checks++; if (r_err !== 1'b1 || r_lat !== 1) begin errors++; $display("FAIL err_%0d got err=%b lat=%0d exp err=1 lat=1", i, r_err, r_lat); end
            checks++; if (r_rdata !== 32'h0 || r_we_cnt !== 0) begin errors++; $display("FAIL err_side_%0d got rdata=%h we=%0d exp 0/0", i, r_rdata, r_we_cnt); end
        end
        do_req(OP_LW, 32'h10, 32'h0);
        checks++; if (r_rdata !== 32'h123455EF || r_err !== 1'b0) begin errors++; $display("FAIL err_mem_intact got=%h err=%b exp=123455ef 0", r_rdata, r_err); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  rdy_seen = '0;
        logic [7:0]  vld_seen = '0;
        logic [31:0] rdata_k5 = '0;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h20; req_wdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        req_op = OP_LW; req_wdata = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            rdy_seen[k-1] = req_ready;
            vld_seen[k-1] = resp_valid;
            if (k == 5) rdata_k5 = resp_rdata;
            if (k == 4) req_valid = 1'b0;
            @(negedge clk);
        end
        checks++; if (rdy_seen !== 8'b11100100) begin errors++; $display("FAIL b2b_ready got=%b exp=11100100", rdy_seen); end
        checks++; if (vld_seen !== 8'b00010010) begin errors++; $display("FAIL b2b_resp_valid got=%b exp=00010010", vld_seen); end
        checks++; if (rdata_k5 !== 32'h11111111) begin errors++; $display("FAIL b2b_rdata got=%h exp=11111111", rdata_k5); end
        checks++; if (mem[8] !== 32'h11111111) begin errors++; $display("FAIL b2b_mem got=%h exp=11111111", mem[8]); end
    endtask

    task automatic test_reset_mid();
        int extra_resp = 0;
        int extra_we = 0;
        do_req(OP_SW, 32'h14, 32'hCAFEF00D);
        do_req(OP_LW, 32'h14, 32'h0);
        checks++; if (r_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_setup got=%h exp=cafef00d", r_rdata); end
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SH; req_addr = 32'h14; req_wdata = 32'h00001234;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ctrl got ready=%b valid=%b we=%b exp 1/0/0", req_ready, resp_valid, mem_we);
        end
        checks++; if ({mem_a, mem_wd, resp_rdata, resp_err} !== 97'h0) begin
            errors++; $display("FAIL rst_mid_regs a=%h wd=%h rdata=%h err=%b exp all 0", mem_a, mem_wd, resp_rdata, resp_err);
        end
        for (int k = 0; k < 5; k++) begin
            if (resp_valid) extra_resp++;
            if (mem_we) extra_we++;
            @(negedge clk);
        end
        checks++; if (extra_resp !== 0 || extra_we !== 0) begin errors++; $display("FAIL rst_mid_quiet got resp=%0d we=%0d exp 0/0", extra_resp, extra_we); end
        checks++; if (mem[5] !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_mid_mem got=%h exp=cafef00d", mem[5]); end
        do_req(OP_LHU, 32'h16, 32'h0);
        checks++; if (r_rdata !== 32'h0000CAFE || r_lat !== 2) begin errors++; $display("FAIL rst_mid_recover got=%h lat=%0d exp=0000cafe 2", r_rdata, r_lat); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword_load();
        test_subword_store();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
